led_chaser_pwm: RTL and testbench
=================================

LED_CHASER_PWM -- requirements
Module: led_chaser_pwm

Interface
REQ-001 Parameter N_CH, default 16: number of LED channels, range 4..64.
REQ-002 Parameter PWM_W, default 8: PWM resolution in bits; MAX = 2^PWM_W-1.
REQ-003 Parameter BASE_DIV, default 1000000: step-period unit in clk cycles, minimum 1.
REQ-004 Port: clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: buttons  input  5  speed select, one-hot.
REQ-007 Port: mode  input  2  00 rotate-up, 01 rotate-down, 10 bounce, 11 freeze.
REQ-008 Port: led  output  N_CH  registered PWM outputs.
REQ-009 Port: pos  output  clog2(N_CH)  current head index.
REQ-010 Port: step  output  1  one-cycle pulse on every step tick.

Function
REQ-011 The step period P SHALL be k*BASE_DIV: buttons 00001 gives k=5, 00010 gives 4, 00100 gives 3, 01000 gives 2, 10000 gives 1, and any other value gives 5.
REQ-012 The divider SHALL count 0..P_q-1 and assert step for one cycle when the count equals P_q-1, then return to 0; P_q SHALL load the new P only at that wrap, so a mid-period button change does not take effect until the next period.
REQ-013 On a step in rotate-up mode, pos SHALL increment modulo N_CH, with N_CH-1 wrapping to 0, and dir SHALL be set to up.
REQ-014 On a step in rotate-down mode, pos SHALL decrement modulo N_CH, with 0 wrapping to N_CH-1, and dir SHALL be set to down.
REQ-015 On a step in bounce mode, pos SHALL move one position in the direction of dir; at pos=N_CH-1 with dir up, the next pos SHALL be N_CH-2 and dir SHALL become down; at pos=0 with dir down, the next pos SHALL be 1 and dir SHALL become up.
REQ-016 In freeze mode, pos and dir SHALL be held and step SHALL still pulse.
REQ-017 A mode change SHALL take effect at the next step and SHALL keep the current pos.
REQ-018 The trail distance d for channel i SHALL be computed as follows: if dir is up, d=(pos-i) mod N_CH; if dir is down, d=(i-pos) mod N_CH; in bounce mode, a channel on the far side of the head (i>pos when dir is up, i<pos when dir is down) SHALL have d set to infinity.
REQ-019 The target duty for channel i SHALL be MAX>>d when d<PWM_W, and 0 otherwise.
REQ-020 A free-running PWM counter SHALL count 0..MAX-1 and wrap to 0.
REQ-021 Duty registers SHALL load target duties only in the cycle where the PWM counter equals 0 (glitch-free double-buffering).
REQ-022 led[i] SHALL be registered as (cnt < duty_q[i]): duty MAX gives a constant on, duty 0 gives a constant off.
REQ-023 When a step tick and a PWM wrap occur in the same cycle, the duty registers SHALL load targets computed from the pre-step pos, and the new pos SHALL appear in the duty registers at the next PWM wrap.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set divider=0, P_q=5*BASE_DIV, pos=0, dir=up, PWM cnt=0, all duty_q=0, led=0, step=0.
REQ-025 Reset asserted mid-period or mid-bounce SHALL take priority over every other update.
REQ-026 On the first cycle after reset release, the divider and the PWM counter SHALL both start from 0.

Configuration
REQ-027 With macro LED_CHASER_BTN_SYNC_EN defined, buttons and mode SHALL pass through a two-flop synchroniser before use, with both flops reset to 0, which adds 2 cycles of latency.
REQ-028 Without LED_CHASER_BTN_SYNC_EN defined, buttons and mode SHALL be used directly and no synchroniser flops SHALL exist.

Verification (N_CH=8, PWM_W=4, BASE_DIV=2, macro undefined unless stated)
REQ-029 Scenario: buttons=00000, mode=00 after reset -> step pulses every 10 cycles, pos sequence 1,2,...,7,0.
REQ-030 Scenario: buttons set to 10000 mid-period -> the current period stays 10 cycles and the next periods are 2 cycles.
REQ-031 Scenario: mode=10 from pos=5 -> pos sequence 6,7,6,5,...,0,1; dir flips exactly at 7 and at 0.
REQ-032 Scenario: pos=3, dir up, mode=00 -> after the next PWM wrap, duty_q[3]=15, duty_q[2]=7, duty_q[1]=3, duty_q[0]=1, all others 0; led[3] stays high for a full 15-cycle PWM period, led[2] is high for 7 of 15 cycles.
REQ-033 Scenario: mode=10, pos=0, dir up -> channels 1..7 have duty 0; no wrap-around trail.
REQ-034 Scenario: rst pulsed mid-bounce with the macro defined -> all outputs return to reset values; a button change reaches P_q only after 2 synchroniser cycles plus the next wrap.

Source files
------------

// File: rtl/led_chaser_pwm.sv
// LED chaser: a stepping head with an exponentially fading, PWM-dimmed trail.
// Optional feature: define LED_CHASER_BTN_SYNC_EN to synchronise buttons/mode.
module led_chaser_pwm #(
  parameter int N_CH     = 16,
  parameter int PWM_W    = 8,
  parameter int BASE_DIV = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              buttons,
  input  logic [1:0]              mode,
  output logic [N_CH-1:0]         led,
  output logic [$clog2(N_CH)-1:0] pos,
  output logic                    step
);

  localparam int POS_W = $clog2(N_CH);
  localparam int DIV_W = $clog2(5 * BASE_DIV + 1);
  localparam logic [PWM_W-1:0] MAX  = '1;
  localparam logic [POS_W-1:0] LAST = POS_W'(N_CH - 1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  logic [4:0] btn_use;
  mode_e      mode_use;

`ifdef LED_CHASER_BTN_SYNC_EN
  logic [4:0] btn_s1, btn_s2;
  logic [1:0] mode_s1, mode_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
    end else begin
      btn_s1  <= buttons;
      btn_s2  <= btn_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
    end
  end

  assign btn_use  = btn_s2;
  assign mode_use = mode_e'(mode_s2);
`else
  assign btn_use  = buttons;
  assign mode_use = mode_e'(mode);
`endif

  // Step divider; the period only changes at a wrap so a period is never cut short.
  logic [DIV_W-1:0] div_cnt, p_q, p_sel;
  logic             tick;

  always_comb begin
    case (btn_use)
      5'b00001: p_sel = DIV_W'(5 * BASE_DIV);
      5'b00010: p_sel = DIV_W'(4 * BASE_DIV);
      5'b00100: p_sel = DIV_W'(3 * BASE_DIV);
      5'b01000: p_sel = DIV_W'(2 * BASE_DIV);
      5'b10000: p_sel = DIV_W'(BASE_DIV);
      default:  p_sel = DIV_W'(5 * BASE_DIV);
    endcase
  end

  assign tick = (div_cnt == p_q - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      p_q     <= DIV_W'(5 * BASE_DIV);
      step    <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        div_cnt <= '0;
        p_q     <= p_sel;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  dir_e             dir, dir_nxt;
  logic [POS_W-1:0] pos_nxt;

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (tick) begin
      case (mode_use)
        MODE_UP: begin
          pos_nxt = (pos == LAST) ? '0 : pos + POS_W'(1);
          dir_nxt = DIR_UP;
        end
        MODE_DOWN: begin
          pos_nxt = (pos == '0) ? LAST : pos - POS_W'(1);
          dir_nxt = DIR_DOWN;
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (pos == LAST) begin
              pos_nxt = pos - POS_W'(1);
              dir_nxt = DIR_DOWN;
            end else begin
              pos_nxt = pos + POS_W'(1);
            end
          end else begin
            if (pos == '0) begin
              pos_nxt = POS_W'(1);
              dir_nxt = DIR_UP;
            end else begin
              pos_nxt = pos - POS_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
      dir <= DIR_UP;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

  // Trail distance behind the head; bounce mode never wraps the trail around.
  logic [PWM_W-1:0] target [N_CH];
  int               trail_p;
  int               trail_d;
  logic             trail_far;

  always_comb begin
    trail_p   = int'(pos);
    trail_d   = 0;
    trail_far = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (dir == DIR_UP) begin
        trail_d   = trail_p - i;
        trail_far = (i > trail_p);
      end else begin
        trail_d   = i - trail_p;
        trail_far = (i < trail_p);
      end
      if (trail_d < 0) trail_d = trail_d + N_CH;
      if (mode_use == MODE_BOUNCE && trail_far) target[i] = '0;
      else if (trail_d < PWM_W)                  target[i] = MAX >> trail_d;
      else                                       target[i] = '0;
    end
  end

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_q [N_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      led <= '0;
      for (int i = 0; i < N_CH; i++) duty_q[i] <= '0;
    end else begin
      cnt <= (cnt == MAX - PWM_W'(1)) ? '0 : cnt + PWM_W'(1);
      for (int i = 0; i < N_CH; i++) led[i] <= (cnt < duty_q[i]);
      if (cnt == '0) begin
        for (int i = 0; i < N_CH; i++) duty_q[i] <= target[i];
      end
    end
  end

endmodule

// File: tb/tb_led_chaser_pwm.sv
// Randomised bench for led_chaser_pwm against a cycle-level behavioural model.
// Follows LED_CHASER_BTN_SYNC_EN when it is defined for the compile.
module tb_led_chaser_pwm;

  localparam int N    = 8;
  localparam int PW   = 4;
  localparam int BD   = 2;
  localparam int MAXV = (1 << PW) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   buttons = '0;
  logic [1:0]   mode = '0;
  logic [N-1:0] led;
  logic [2:0]   pos;
  logic         step;

  int checks = 0;
  int errors = 0;

  led_chaser_pwm #(.N_CH(N), .PWM_W(PW), .BASE_DIV(BD)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .mode(mode),
    .led(led), .pos(pos), .step(step)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int           m_div, m_pq, m_pos, m_cnt;
  bit           m_up;
  int           m_duty [N];
  logic [N-1:0] m_led;
  logic         m_step;
  bit           m_valid = 1'b0;
  logic [4:0]   sb1 = '0, sb2 = '0;
  logic [1:0]   sm1 = '0, sm2 = '0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic int periodOf(input logic [4:0] b);
    case (b)
      5'b00001: return 5 * BD;
      5'b00010: return 4 * BD;
      5'b00100: return 3 * BD;
      5'b01000: return 2 * BD;
      5'b10000: return BD;
      default:  return 5 * BD;
    endcase
  endfunction

  task automatic modelEdge(input logic r, input logic [4:0] b, input logic [1:0] m);
    logic [4:0] bu;
    logic [1:0] mu;
    int         tgt [N];
    int         ch;
    bit         tick;
`ifdef LED_CHASER_BTN_SYNC_EN
    bu = sb2;
    mu = sm2;
    if (r) begin
      sb1 = '0; sb2 = '0; sm1 = '0; sm2 = '0;
    end else begin
      sb2 = sb1; sb1 = b; sm2 = sm1; sm1 = m;
    end
`else
    bu = b;
    mu = m;
`endif
    if (r) begin
      m_div = 0; m_pq = 5 * BD; m_pos = 0; m_up = 1'b1; m_cnt = 0;
      foreach (m_duty[i]) m_duty[i] = 0;
      m_led = '0; m_step = 1'b0; m_valid = 1'b1;
      return;
    end
    tick   = (m_div == m_pq - 1);
    m_step = tick;
    for (int i = 0; i < N; i++) m_led[i] = (m_cnt < m_duty[i]);
    if (m_cnt == 0) begin
      foreach (tgt[i]) tgt[i] = 0;
      // walk backwards from the head, halving brightness each channel
      for (int d = 0; d < PW; d++) begin
        ch = m_up ? m_pos - d : m_pos + d;
        if (mu == 2'b10) begin
          if (ch < 0 || ch >= N) continue;
        end else begin
          ch = (ch + N) % N;
        end
        tgt[ch] = MAXV >> d;
      end
      foreach (m_duty[i]) m_duty[i] = tgt[i];
    end
    m_cnt = (m_cnt == MAXV - 1) ? 0 : m_cnt + 1;
    if (tick) begin
      m_div = 0;
      m_pq  = periodOf(bu);
      case (mu)
        2'b00: begin m_pos = (m_pos + 1) % N; m_up = 1'b1; end
        2'b01: begin m_pos = (m_pos + N - 1) % N; m_up = 1'b0; end
        2'b10: begin
          if (m_up) begin
            if (m_pos == N - 1) begin m_pos = N - 2; m_up = 1'b0; end
            else m_pos = m_pos + 1;
          end else begin
            if (m_pos == 0) begin m_pos = 1; m_up = 1'b1; end
            else m_pos = m_pos - 1;
          end
        end
        default: begin end
      endcase
    end else begin
      m_div = m_div + 1;
    end
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic [1:0] m, input int cycles, input logic r);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (m_valid) begin
        checkOutput("pos", 64'(pos), 64'(m_pos));
        checkOutput("step", 64'(step), 64'(m_step));
        checkOutput("led", 64'(led), 64'(m_led));
      end
      buttons = b;
      mode    = m;
      rst     = r;
      @(posedge clk);
      modelEdge(r, b, m);
    end
  endtask

  initial begin
    int  k;
    bit  found;

    applyStimulus(5'b00000, 2'b00, 3, 1'b1);
    #1;
    checkOutput("rst_led", 64'(led), 64'(0));
    checkOutput("rst_pos", 64'(pos), 64'(0));
    checkOutput("rst_step", 64'(step), 64'(0));

    // first step must arrive ten cycles after release (default period 5*BASE_DIV)
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      applyStimulus(5'b00000, 2'b00, 1, 1'b0);
      k++;
      #1;
      if (step === 1'b1) found = 1'b1;
    end
    checkOutput("first_step_cycle", 64'(k), 64'(10));
    checkOutput("first_step_pos", 64'(pos), 64'(1));

    applyStimulus(5'b00000, 2'b00, 80, 1'b0);
    applyStimulus(5'b00000, 2'b00, 4, 1'b0);
    applyStimulus(5'b10000, 2'b00, 40, 1'b0);
    applyStimulus(5'b10000, 2'b10, 150, 1'b0);
    applyStimulus(5'b01000, 2'b01, 60, 1'b0);
    applyStimulus(5'b00100, 2'b11, 40, 1'b0);
    applyStimulus(5'b00010, 2'b00, 60, 1'b0);
    applyStimulus(5'b10000, 2'b10, 37, 1'b0);

    applyStimulus(5'b10000, 2'b10, 2, 1'b1);
    #1;
    checkOutput("midbounce_rst_led", 64'(led), 64'(0));
    checkOutput("midbounce_rst_pos", 64'(pos), 64'(0));
    checkOutput("midbounce_rst_step", 64'(step), 64'(0));
    applyStimulus(5'b10000, 2'b10, 60, 1'b0);

    for (int ph = 0; ph < 60; ph++) begin
      logic [4:0] b;
      logic [1:0] m;
      int         len;
      if ($urandom_range(0, 3) != 0) b = 5'b00001 << $urandom_range(0, 4);
      else                           b = 5'($urandom);
      m   = 2'($urandom);
      len = $urandom_range(5, 60);
      if ($urandom_range(0, 19) == 0) applyStimulus(b, m, $urandom_range(1, 2), 1'b1);
      applyStimulus(b, m, len, 1'b0);
    end
    applyStimulus(5'b00000, 2'b00, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
